// File: rtl/mesh_term_src_fifo.sv
// rtl/mesh_term_src_fifo.sv - per-terminal show-ahead injection FIFO with occupancy and sticky error flags
module mesh_term_src_fifo #(
  parameter int pckg_sz    = 40,
  parameter int fifo_depth = 4,
  localparam int CNT_W     = $clog2(fifo_depth + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [pckg_sz-1:0] data_in,
  output logic               full,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  output logic [CNT_W-1:0]   count,
  output logic               overflow,
  output logic               underflow,
  input  logic               clr_flags
);

  localparam int PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(fifo_depth - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(fifo_depth);

  logic [pckg_sz-1:0] mem [0:fifo_depth-1];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               empty;
  logic               acc_push;
  logic               acc_pop;
  logic               ovf_evt;
  logic               udf_evt;

  // Status is derived from registered count only, so no path from push/popin
  always_comb begin
    empty         = (count == '0);
    full          = (count == DEPTH_CNT);
    pndng_i_in    = !empty;
    data_out_i_in = empty ? '0 : mem[rd_ptr];
  end

  // Accept/drop decisions; a pop on a full FIFO frees the slot the push reuses
  always_comb begin
    acc_push = push && (!full || popin);
    acc_pop  = popin && !empty;
    ovf_evt  = push && !acc_push;
    udf_evt  = popin && empty;
  end

  // Packet storage; not reset, the output mux hides stale contents when empty
  always_ff @(posedge clk) begin
    if (reset && acc_push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers and occupancy; pointers wrap at fifo_depth-1 so any depth works
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (acc_push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (acc_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      case ({acc_push, acc_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow && !clr_flags) || ovf_evt;
      underflow <= (underflow && !clr_flags) || udf_evt;
    end
  end

endmodule
